// File: rtl/mult_arbiter_pkg.sv
// Shared types and widths for the two-requester shared-multiplier arbiter.
package mult_arbiter_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 2 * OP_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            id;
  } op_t;

  // Round-robin pick: lone valid wins, a tie goes to the side not served last.
  function automatic logic pick_id(input logic v0, input logic v1, input logic last);
    return (v0 & v1) ? ~last : v1;
  endfunction

endpackage

// File: rtl/mult_arbiter_mult.sv
// 4x4 unsigned carry-save array multiplier built from AND-gated full-adder
// cells, with a ripple adder merging the last sum/carry rows.
module array_mult4
  import mult_arbiter_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  logic [OP_W-1:0] pp [OP_W];
  logic [OP_W:0]   s  [OP_W];
  logic [OP_W-1:0] c  [OP_W];
  logic [OP_W-1:0] fc;

  genvar i, j;
  generate
    for (i = 0; i < OP_W; i++) begin : g_pp
      for (j = 0; j < OP_W; j++) begin : g_bit
        assign pp[i][j] = a[j] & b[i];
      end
      assign s[i][OP_W] = 1'b0;
      assign p[i]       = s[i][0];
    end

    for (j = 0; j < OP_W; j++) begin : g_row0
      assign s[0][j] = pp[0][j];
      assign c[0][j] = 1'b0;
    end

    // Cell (i,j) sums three terms of weight i+j: its partial product, the
    // previous row's sum one column up and the previous row's carry.
    for (i = 1; i < OP_W; i++) begin : g_row
      for (j = 0; j < OP_W; j++) begin : g_fa
        logic x, y, z;
        assign x       = pp[i][j];
        assign y       = s[i-1][j+1];
        assign z       = c[i-1][j];
        assign s[i][j] = x ^ y ^ z;
        assign c[i][j] = (x & y) | (x & z) | (y & z);
      end
    end

    assign fc[0] = 1'b0;
    for (j = 0; j < OP_W; j++) begin : g_final
      logic x, y;
      assign x           = s[OP_W-1][j+1];
      assign y           = c[OP_W-1][j];
      assign p[OP_W + j] = x ^ y ^ fc[j];
      if (j < OP_W - 1) begin : g_carry
        assign fc[j+1] = (x & y) | (x & fc[j]) | (y & fc[j]);
      end
    end
  endgenerate

endmodule

// File: rtl/mult_arbiter.sv
// Two requesters share one 4x4 multiplier: grant in IDLE, multiply in CALC,
// hold the product in RESP until the consumer takes it.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  output logic              req1_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_product,
  output logic              res_id,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  state_t            state, state_nxt;
  op_t               op;
  logic              last_id;
  logic              gnt_vld, gnt_id, req_hs, res_hs;
  logic [PROD_W-1:0] mult_p;
  logic [CNT_W-1:0]  cnt [2];

  assign gnt_vld = req0_valid | req1_valid;
  assign gnt_id  = pick_id(req0_valid, req1_valid, last_id);
  assign req_hs  = (state == IDLE) && gnt_vld;
  assign res_hs  = (state == RESP) && res_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld)   state_nxt = CALC;
      CALC:                   state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && gnt_vld && !gnt_id;
    req1_ready = (state == IDLE) && gnt_vld &&  gnt_id;
    res_valid  = (state == RESP);
  end

  // Reset leaves last_id at 1 so the first tie goes to requester 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op      <= '0;
      last_id <= 1'b1;
    end else if (req_hs) begin
      op.a    <= gnt_id ? req1_a : req0_a;
      op.b    <= gnt_id ? req1_b : req0_b;
      op.id   <= gnt_id;
      last_id <= gnt_id;
    end
  end

  array_mult4 u_mult (
    .a (op.a),
    .b (op.b),
    .p (mult_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_product <= '0;
      res_id      <= 1'b0;
    end else if (state == CALC) begin
      res_product <= mult_p;
      res_id      <= op.id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else if (res_hs) begin
      cnt[res_id] <= cnt[res_id] + 1'b1;
    end
  end

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized self-checking bench; the model tracks last-served requester,
// expected products and per-requester completion counts.
module tb_mult_arbiter;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]       req0_a, req0_b, req1_a, req1_b;
  logic             res_valid, res_ready, res_id;
  logic [7:0]       res_product;
  logic [CNT_W-1:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;
  int m_last;
  int m_cnt [2];

  mult_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .res_id(res_id), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_last   = 1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 0; req1_valid = 0; res_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One full transaction: grant, CALC, RESP (optionally held), completion.
  task automatic do_op(input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                       input bit v1, input logic [3:0] a1, input logic [3:0] b1,
                       input int hold, input bit early);
    int g;
    logic [7:0] ep;
    if (v0 && v1) g = 1 - m_last;
    else          g = v0 ? 0 : 1;
    ep = (g == 0) ? 8'(int'(a0) * int'(b0)) : 8'(int'(a1) * int'(b1));
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = 1'b0;
    #1;
    checks++;
    if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
      failures++;
      $display("FAIL grant: ready0=%b ready1=%b expected winner %0d", req0_ready, req1_ready, g);
    end
    m_last = g;
    @(negedge clk);
    req0_valid = 1; req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_valid = 1; req1_a = 4'($urandom); req1_b = 4'($urandom);
    res_ready  = early;
    #1;
    checks++;
    if (res_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL calc_phase: res_valid=%b ready0=%b ready1=%b expected 0 0 0", res_valid, req0_ready, req1_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b1 || res_product !== ep || res_id !== 1'(g)) begin
      failures++;
      $display("FAIL response: valid=%b product=%0d id=%b expected 1 %0d %0d", res_valid, res_product, res_id, ep, g);
    end
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_product !== ep || res_id !== 1'(g) ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          failures++;
          $display("FAIL hold: valid=%b product=%0d id=%b r0=%b r1=%b expected 1 %0d %0d 0 0",
                   res_valid, res_product, res_id, req0_ready, req1_ready, ep, g);
        end
      end
    end
    req0_valid = 0; req1_valid = 0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    m_cnt[g] = (m_cnt[g] + 1) % (1 << CNT_W);
    #1;
    checks++;
    if (res_valid !== 1'b0 || cnt0 !== CNT_W'(m_cnt[0]) || cnt1 !== CNT_W'(m_cnt[1])) begin
      failures++;
      $display("FAIL complete: valid=%b cnt0=%0d cnt1=%0d expected 0 %0d %0d", res_valid, cnt0, cnt1, m_cnt[0], m_cnt[1]);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (res_valid !== 1'b0 || res_product !== 8'd0 || res_id !== 1'b0 || cnt0 !== '0 || cnt1 !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b product=%0d id=%b cnt0=%0d cnt1=%0d expected all 0",
               res_valid, res_product, res_id, cnt0, cnt1);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority: ready0=%b ready1=%b expected 1 0", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_max();
    do_op(1, 4'd15, 4'd15, 0, 4'd0, 4'd0, 0, 1);
  endtask

  task automatic test_both_valid();
    apply_reset();
    do_op(1, 4'd3, 4'd4, 1, 4'd5, 4'd6, 0, 1);
    do_op(0, 4'd0, 4'd0, 1, 4'd5, 4'd6, 0, 1);
  endtask

  task automatic test_backpressure();
    do_op(0, 4'd0, 4'd0, 1, 4'd9, 4'd7, 5, 0);
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    req0_valid = 1; req0_a = 4'd10; req0_b = 4'd10; req1_valid = 0;
    @(negedge clk);
    req0_valid = 0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || cnt0 !== '0 || cnt1 !== '0) begin
        failures++;
        $display("FAIL abandon: valid=%b cnt0=%0d cnt1=%0d expected 0 0 0", res_valid, cnt0, cnt1);
      end
    end
    do_op(1, 4'd2, 4'd3, 1, 4'd4, 4'd5, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      do_op(v0, 4'($urandom), 4'($urandom), v1, 4'($urandom), 4'($urandom),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_exhaustive();
    apply_reset();
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kv;
      kv = 8'(k);
      if (k % 2 == 0) do_op(1, kv[7:4], kv[3:0], 0, 4'd0, 4'd0, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
      else            do_op(0, 4'd0, 4'd0, 1, kv[7:4], kv[3:0], $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int k = 0; k < 256; k++)
      do_op(1, 4'($urandom), 4'($urandom), 0, 4'd0, 4'd0, 0, 1);
    checks++;
    if (cnt0 !== '0 || cnt1 !== '0) begin
      failures++;
      $display("FAIL wrap: cnt0=%0d cnt1=%0d expected 0 0", cnt0, cnt1);
    end
  endtask

  initial begin
    rst_n = 1'b0; req0_valid = 0; req1_valid = 0; res_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    model_reset();
    test_reset();
    test_max();
    test_both_valid();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    test_exhaustive();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
